afe_switch_driver: RTL

AFE_SWITCH_DRIVER -- requirements
Module: afe_switch_driver

---
 rtl/afe_pkg.sv | 52 +++++
 rtl/afe_switch_driver_sync_filter.sv | 52 +++++
 rtl/afe_switch_driver.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/afe_pkg.sv
// afe_pkg: shared definitions for the AFE switch driver.
//   afe_sel_e   - AFE phase encodings, shared with the measurement FSM
//   afe_state_e - switch driver FSM states
//   afe_cfg_t   - requested/applied switch configuration {phase, ref polarity}
//   afe_make_cfg- builds a config, masking ref_sign outside DEINTEGRATE
//   afe_decode  - config -> {sw_az, sw_in, sw_refp, sw_refn}
package afe_pkg;

  typedef enum logic [1:0] {
    AFE_IDLE        = 2'b00,
    AFE_AUTO_ZERO   = 2'b01,
    AFE_INTEGRATE   = 2'b10,
    AFE_DEINTEGRATE = 2'b11
  } afe_sel_e;

  typedef enum logic [1:0] {
    S_OPEN   = 2'b00,
    S_BREAK  = 2'b01,
    S_ACTIVE = 2'b10
  } afe_state_e;

  typedef struct packed {
    afe_sel_e sel;
    logic     ref_sign;
  } afe_cfg_t;

  // Width of the dead-time and filter counters (legal parameter range 1..15).
  localparam int unsigned CNT_W = 4;

  // ref_sign is forced to 0 outside DEINTEGRATE so that toggling it in other
  // phases is not seen as a configuration change.
  function automatic afe_cfg_t afe_make_cfg(input logic [1:0] sel, input logic ref_sign);
    afe_cfg_t c;
    c.sel      = afe_sel_e'(sel);
    c.ref_sign = (c.sel == AFE_DEINTEGRATE) ? ref_sign : 1'b0;
    return c;
  endfunction

  // Returns {az, in, refp, refn}; at most one bit set.
  function automatic logic [3:0] afe_decode(input afe_cfg_t c);
    logic [3:0] sw;
    sw = '0;
    case (c.sel)
      AFE_AUTO_ZERO:   sw = 4'b1000;
      AFE_INTEGRATE:   sw = 4'b0100;
      AFE_DEINTEGRATE: sw = c.ref_sign ? 4'b0010 : 4'b0001;
      default:         sw = '0;
    endcase
    return sw;
  endfunction

endpackage

// File: rtl/afe_switch_driver_sync_filter.sv
// sync_filter: 2-flop synchronizer followed by a stability filter.
// The filtered flag takes the synchronized level only after FILTER_LEN
// consecutive samples that differ from the current flag.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset (clears synchronizer and filter)
//   raw_i   - asynchronous input
//   filt_o  - synchronized, filtered level
module sync_filter
  import afe_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             r_meta;
  logic             r_sync;
  logic             r_flag;
  logic [CNT_W-1:0] r_cnt;

  // The counter is cleared on every toggle and whenever the sample agrees
  // with the flag, so it never exceeds FILTER_LEN-1 and cannot wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= raw_i;
      r_sync <= r_meta;
      if (r_sync == r_flag) begin
        r_cnt <= '0;
      end else if (r_cnt >= LAST) begin
        r_flag <= r_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign filt_o = r_flag;

endmodule

// File: rtl/afe_switch_driver.sv
// afe_switch_driver: break-before-make driver for the AFE analog switches,
// plus synchronized/filtered comparator and saturation flags.
// Ports:
//   clk_i, rst_ni                  - clock, asynchronous active-low reset
//   afe_sel_i, ref_sign_i          - requested phase and deintegrate polarity
//   afe_reset_i                    - integrator short request (-> sw_rst_o, 1 clk)
//   comp_raw_i, sat_hi_raw_i, sat_lo_raw_i - asynchronous comparator inputs
//   sw_az_o, sw_in_o, sw_refp_o, sw_refn_o - switch enables (one-hot or none)
//   sw_rst_o                       - integrator capacitor short
//   comp_o, sat_hi_o, sat_lo_o     - filtered flags
//   busy_o                         - high during the all-open break interval
// Build option: define AFE_SAT_LATCH_EN to make sat_hi_o/sat_lo_o sticky
// until cleared by sw_rst_o while the filtered input is low.
module afe_switch_driver
  import afe_pkg::*;
#(
  parameter int unsigned DEADTIME_CYCLES = 2,
  parameter int unsigned FILTER_LEN      = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] afe_sel_i,
  input  logic       ref_sign_i,
  input  logic       afe_reset_i,
  input  logic       comp_raw_i,
  input  logic       sat_hi_raw_i,
  input  logic       sat_lo_raw_i,
  output logic       sw_az_o,
  output logic       sw_in_o,
  output logic       sw_refp_o,
  output logic       sw_refn_o,
  output logic       sw_rst_o,
  output logic       comp_o,
  output logic       sat_hi_o,
  output logic       sat_lo_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] DT  = CNT_W'(DEADTIME_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  afe_cfg_t         r_req;
  afe_cfg_t         r_target;
  afe_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_sw;
  logic             r_busy;
  logic             r_sw_rst;
  logic             w_comp;
  logic             w_sat_hi;
  logic             w_sat_lo;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req <= '0;
    end else begin
      r_req <= afe_make_cfg(afe_sel_i, ref_sign_i);
    end
  end

  // r_target is the pending configuration in S_BREAK and the applied one in
  // S_ACTIVE. Any difference from the registered request (re)starts a full
  // break, including a return to the previously applied configuration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_OPEN;
      r_target <= '0;
      r_cnt    <= '0;
      r_sw     <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_OPEN: begin
          if (r_req.sel != AFE_IDLE) begin
            r_state  <= S_BREAK;
            r_target <= r_req;
            r_cnt    <= DT;
            r_sw     <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_BREAK: begin
          if (r_req != r_target) begin
            r_target <= r_req;
            r_cnt    <= DT;
          end else if (r_cnt <= ONE) begin
            r_state <= S_ACTIVE;
            r_sw    <= afe_decode(r_target);
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        S_ACTIVE: begin
          if (r_req != r_target) begin
            r_state  <= S_BREAK;
            r_target <= r_req;
            r_cnt    <= DT;
            r_sw     <= '0;
            r_busy   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_OPEN;
          r_sw    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Integrator short is held during reset and otherwise tracks the request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw_rst <= 1'b1;
    end else begin
      r_sw_rst <= afe_reset_i;
    end
  end

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_comp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (comp_raw_i),
    .filt_o (w_comp)
  );

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sat_hi (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (sat_hi_raw_i),
    .filt_o (w_sat_hi)
  );

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sat_lo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (sat_lo_raw_i),
    .filt_o (w_sat_lo)
  );

`ifdef AFE_SAT_LATCH_EN
  logic r_hi_st;
  logic r_lo_st;

  // Sticky bit ORed with the live level: sets with no extra latency and
  // clears the cycle after sw_rst_o is seen while the filtered input is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi_st <= 1'b0;
      r_lo_st <= 1'b0;
    end else begin
      if (w_sat_hi)      r_hi_st <= 1'b1;
      else if (r_sw_rst) r_hi_st <= 1'b0;
      if (w_sat_lo)      r_lo_st <= 1'b1;
      else if (r_sw_rst) r_lo_st <= 1'b0;
    end
  end

  assign sat_hi_o = w_sat_hi | r_hi_st;
  assign sat_lo_o = w_sat_lo | r_lo_st;
`else
  assign sat_hi_o = w_sat_hi;
  assign sat_lo_o = w_sat_lo;
`endif

  assign {sw_az_o, sw_in_o, sw_refp_o, sw_refn_o} = r_sw;
  assign sw_rst_o = r_sw_rst;
  assign comp_o   = w_comp;
  assign busy_o   = r_busy;

endmodule
